ram_sdp_rd_streamer: RTL and testbench



---
 rtl/ram_sdp_rd_streamer_if.sv | 30 +++
 rtl/ram_sdp_rd_streamer.sv | 150 +++++++++++++++
 tb/tb_ram_sdp_rd_streamer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_sdp_rd_streamer_if.sv
// Bus bundle for the RAM read streamer: command channel, RAM read port and output stream.
// The master modport is the streamer side; the slave modport is its environment.
interface ram_sdp_rd_streamer_if #(
  parameter int unsigned RD_ADDR_W = 6,
  parameter int unsigned RD_DATA_W = 32,
  parameter int unsigned LEN_W     = RD_ADDR_W + 1
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [RD_ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  logic                 busy;
  logic                 ram_rd_en;
  logic [RD_ADDR_W-1:0] ram_rd_addr;
  logic [RD_DATA_W-1:0] ram_rd_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [RD_DATA_W-1:0] m_data;
  logic                 m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
    output cmd_ready, busy, ram_rd_en, ram_rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
    input  cmd_ready, busy, ram_rd_en, ram_rd_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_sdp_rd_streamer.sv
// Burst read engine: issues sequential RAM reads, tracks the fixed read latency with a tag
// pipeline and streams the returned words through a credit-protected output FIFO.
module ram_sdp_rd_streamer #(
  parameter int unsigned RD_ADDR_W  = 6,
  parameter int unsigned RD_DATA_W  = 32,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned LEN_W      = RD_ADDR_W + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_sdp_rd_streamer_if.master bus
);

  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [RD_ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [RD_LATENCY-1:0]  tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0]  tag_last_q, tag_last_d;
  logic [CntW-1:0]        inflight_q, inflight_d;
  logic [CntW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [RD_DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                   fifo_last_q [FIFO_DEPTH];
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   rd_en_q, rd_en_d;

  logic cmd_hs, credit_ok, issue, push, pop, fifo_nonempty;

  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign cmd_hs        = bus.cmd_valid && cmd_ready_q;
  // A pop in the same cycle is deliberately not credited, so the FIFO can never overflow.
  assign credit_ok     = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < (CntW + 1)'(FIFO_DEPTH);
  assign issue         = (state_q == StIssue) && (remaining_q != '0) && credit_ok;
  assign push          = tag_vld_q[RD_LATENCY-1];
  assign pop           = fifo_nonempty && bus.m_ready;

  always_comb begin
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = issue;
    tag_last_d[0] = issue && (remaining_q == LEN_W'(1));
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end

    inflight_d = inflight_q + CntW'(issue) - CntW'(push);
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          if (bus.cmd_len != '0) begin
            addr_d      = bus.cmd_addr;
            remaining_d = bus.cmd_len;
            state_d     = StIssue;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d      = addr_q + RD_ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((inflight_d == '0) && (fifo_cnt_d == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    // A zero-length burst passes through DRAIN straight from IDLE without touching the RAM.
    rd_en_d     = (state_d == StIssue) || ((state_d == StDrain) && (state_q != StIdle));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.ram_rd_data;
        fifo_last_q[wr_ptr_q] <= tag_last_q[RD_LATENCY-1];
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.ram_rd_en   = rd_en_q;
  assign bus.ram_rd_addr = addr_q;
  assign bus.m_valid     = fifo_nonempty;
  assign bus.m_data      = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.m_last      = fifo_nonempty && fifo_last_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ram_sdp_rd_streamer.sv
// Directed bench for ram_sdp_rd_streamer: burst vector table plus reset and back-to-back cases.
module tb_ram_sdp_rd_streamer;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned LW  = AW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_sdp_rd_streamer_if #(.RD_ADDR_W(AW), .RD_DATA_W(DW), .LEN_W(LW)) bus_if ();

  ram_sdp_rd_streamer #(
    .RD_ADDR_W (AW),
    .RD_DATA_W (DW),
    .RD_LATENCY(LAT),
    .LEN_W     (LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // RAM model: mem[i] = i, rd_en advances the whole read pipeline.
  logic [DW-1:0] mem  [2**AW];
  logic [DW-1:0] pipe [LAT];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
  always @(posedge clk) begin
    if (bus_if.ram_rd_en) begin
      pipe[0] <= mem[bus_if.ram_rd_addr];
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus_if.ram_rd_data = pipe[LAT-1];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 0);
    chk("rst_busy",      32'(bus_if.busy), 0);
    chk("rst_rd_en",     32'(bus_if.ram_rd_en), 0);
    chk("rst_rd_addr",   32'(bus_if.ram_rd_addr), 0);
    chk("rst_m_valid",   32'(bus_if.m_valid), 0);
    chk("rst_m_last",    32'(bus_if.m_last), 0);
    chk("rst_m_data",    bus_if.m_data, 0);
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus_if.cmd_ready), 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_len   = len;
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
  endtask

  // Entered just after the accepting edge (cycle T); k counts cycles T+k sampled at negedge.
  task automatic burst_check(input logic [AW-1:0] addr, input int len, input int mode,
                             output logic [31:0] first_word, output logic [31:0] final_word);
    int k = 0;
    int beats = 0;
    int done_k = -1;
    bit first_seen = 0;
    bit fin = 0;
    first_word = '0;
    final_word = '0;
    while (!fin) begin
      @(negedge clk);
      k++;
      bus_if.m_ready = (mode == 0) ? 1'b1 : ((k % 4) == 0);
      if (k > 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL burst_timeout: got %0d beats, expected %0d", beats, len);
        fin = 1;
      end else if (len == 0) begin
        if (k == 1) begin
          chk("zl_busy_hi", 32'(bus_if.busy), 1);
          chk("zl_rd_en",   32'(bus_if.ram_rd_en), 0);
          chk("zl_m_valid", 32'(bus_if.m_valid), 0);
        end else begin
          chk("zl_busy_lo",   32'(bus_if.busy), 0);
          chk("zl_cmd_ready", 32'(bus_if.cmd_ready), 1);
          chk("zl_m_valid2",  32'(bus_if.m_valid), 0);
          fin = 1;
        end
      end else if (done_k >= 0) begin
        chk("busy_fall",       32'(bus_if.busy), 0);
        chk("cmd_ready_after", 32'(bus_if.cmd_ready), 1);
        chk("no_extra_beat",   32'(bus_if.m_valid), 0);
        fin = 1;
      end else begin
        if (k == 1) chk("busy_rise", 32'(bus_if.busy), 1);
        chk("rd_en_busy",     32'(bus_if.ram_rd_en), 1);
        chk("cmd_ready_busy", 32'(bus_if.cmd_ready), 0);
        if (bus_if.m_valid && !first_seen) begin
          first_seen = 1;
          chk("first_latency", 32'(k), 32'(2 + LAT));
        end
        if (bus_if.m_valid && bus_if.m_ready) begin
          chk("beat_data", bus_if.m_data, 32'((int'(addr) + beats) % (2**AW)));
          chk("beat_last", 32'(bus_if.m_last), 32'(beats == len - 1));
          if (beats == 0) first_word = bus_if.m_data;
          final_word = bus_if.m_data;
          beats++;
          if (beats == len) done_k = k;
        end
      end
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            mode;      // 0: m_ready held high, 1: one cycle on, three off
    logic [31:0]   exp_first;
    logic [31:0]   exp_final;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] fw, lw;
    int pops;

    vecs[0] = '{addr: 6'd4,  len: 8,  mode: 0, exp_first: 4,  exp_final: 11};
    vecs[1] = '{addr: 6'd0,  len: 16, mode: 1, exp_first: 0,  exp_final: 15};
    vecs[2] = '{addr: 6'd62, len: 4,  mode: 0, exp_first: 62, exp_final: 1};
    vecs[3] = '{addr: 6'd9,  len: 0,  mode: 0, exp_first: 0,  exp_final: 0};
    vecs[4] = '{addr: 6'd0,  len: 64, mode: 0, exp_first: 0,  exp_final: 63};
    vecs[5] = '{addr: 6'd60, len: 7,  mode: 1, exp_first: 60, exp_final: 2};

    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.m_ready   = 1'b0;
    #3 chk_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_cmd(vecs[v].addr, LW'(vecs[v].len));
      burst_check(vecs[v].addr, vecs[v].len, vecs[v].mode, fw, lw);
      chk("vec_first_word", fw, vecs[v].exp_first);
      chk("vec_final_word", lw, vecs[v].exp_final);
    end

    // Reset in the middle of a 10-beat burst after three pops.
    send_cmd(6'd20, LW'(10));
    bus_if.m_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 50 && pops < 3; k++) begin
      @(negedge clk);
      if (bus_if.m_valid && bus_if.m_ready) pops++;
    end
    chk("pre_reset_pops", 32'(pops), 3);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_reset_no_beat", 32'(bus_if.m_valid), 0);
    end
    send_cmd(6'd0, LW'(2));
    burst_check(6'd0, 2, 0, fw, lw);
    chk("post_reset_first", fw, 0);
    chk("post_reset_final", lw, 1);

    // Back-to-back: second command held valid while the first burst runs.
    @(negedge clk);
    chk("b2b_ready_a", 32'(bus_if.cmd_ready), 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = 6'd10;
    bus_if.cmd_len   = LW'(3);
    @(posedge clk);
    #1;
    bus_if.cmd_addr  = 6'd30;
    bus_if.cmd_len   = LW'(2);
    burst_check(6'd10, 3, 0, fw, lw);
    chk("b2b_a_final", lw, 12);
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    burst_check(6'd30, 2, 0, fw, lw);
    chk("b2b_b_first", fw, 30);
    chk("b2b_b_final", lw, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
